// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int CLA_GROUP = 4;

    function automatic int num_groups(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_group4.sv
// 4-bit lookahead group: in-group carries, sums and group generate/propagate.
module cla_group4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [3:0] c,
    output logic [3:0] s,
    output logic       gg,
    output logic       gp
);

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined CLA adder/subtractor with valid/ready on both sides.
// Handshake: a transfer happens on any rising edge where valid && ready; valid never depends on ready.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = num_groups(WIDTH);

    generate
        if ((GROUP != CLA_GROUP) || (WIDTH % CLA_GROUP != 0) || (WIDTH < CLA_GROUP)) begin : g_bad_cfg
            $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4 and GROUP must be 4");
        end
    endgenerate

    logic             s2_en;
    logic             s1_en;

    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [NG-1:0]    gg_in;
    logic [NG-1:0]    gp_in;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;
    logic             s1_c0;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] sum_nxt;
    logic             ovf_nxt;

    logic [WIDTH-1:0] unused_s1_c;
    logic [WIDTH-1:0] unused_s1_s;
    logic [WIDTH-1:0] unused_s2_c;
    logic [NG-1:0]    unused_s2_gg;
    logic [NG-1:0]    unused_s2_gp;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    assign b_eff = sub ? ~b : b;
    assign c0_in = sub ? 1'b1 : cin;
    assign g_in  = a & b_eff;
    assign p_in  = a ^ b_eff;

    // Stage-1 groups only contribute GG/GP; their carry-in is irrelevant there.
    // Stage-2 groups rebuild in-group carries from the registered g/p and the group carry.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_s1 (
            .p  (p_in[4*k +: 4]),
            .g  (g_in[4*k +: 4]),
            .ci (1'b0),
            .c  (unused_s1_c[4*k +: 4]),
            .s  (unused_s1_s[4*k +: 4]),
            .gg (gg_in[k]),
            .gp (gp_in[k])
        );

        cla_group4 u_s2 (
            .p  (s1_p[4*k +: 4]),
            .g  (s1_g[4*k +: 4]),
            .ci (grp_c[k]),
            .c  (unused_s2_c[4*k +: 4]),
            .s  (sum_nxt[4*k +: 4]),
            .gg (unused_s2_gg[k]),
            .gp (unused_s2_gp[k])
        );
    end

    // Each group carry is a flat sum of products over GG/GP and c0, never chained through C[k].
    always_comb begin
        logic term;
        logic prod;
        term     = 1'b0;
        prod     = 1'b0;
        grp_c    = '0;
        grp_c[0] = s1_c0;
        for (int k = 0; k < NG; k++) begin
            term = s1_c0;
            for (int m = 0; m <= k; m++) begin
                term = term & s1_gp[m];
            end
            for (int j = 0; j <= k; j++) begin
                prod = s1_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    prod = prod & s1_gp[m];
                end
                term = term | prod;
            end
            grp_c[k+1] = term;
        end
    end

    assign ovf_nxt = (s1_a_msb == s1_b_msb) && (sum_nxt[WIDTH-1] != s1_a_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
            s1_gg     <= '0;
            s1_gp     <= '0;
            s1_c0     <= 1'b0;
            s1_a_msb  <= 1'b0;
            s1_b_msb  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_gg    <= gg_in;
                s1_gp    <= gp_in;
                s1_c0    <= c0_in;
                s1_a_msb <= a[WIDTH-1];
                s1_b_msb <= b_eff[WIDTH-1];
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                sum       <= sum_nxt;
                cout      <= grp_c[NG];
                ovf       <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder with a scoreboard queue of expected {cout, ovf, sum}.
module tb_cla_pipe_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic [W+1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_xfer = 0;
    int           run_len = 0;
    int           max_run = 0;
    int           x0;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                           input logic ci, input logic sb);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ov;
        be   = sb ? ~bb : bb;
        full = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        ov   = (aa[W-1] == be[W-1]) && (full[W-1] != aa[W-1]);
        return {full[W], ov, full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on output transfer first, then push on input transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            run_len = 0;
        end else begin
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                n_xfer++;
                check("output_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("result", 32'({cout, ovf, sum}), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci, input logic sb);
        logic ok;
        a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && (exp_q.size() != 0 || out_valid); t++) tick();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic one_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci, input logic sb,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        logic got;
        send(aa, bb, ci, sb);
        in_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("op_out_valid", 32'(got), 32'd1);
        if (got) begin
            check("op_sum", 32'(sum), 32'(e_sum));
            check("op_cout", 32'(cout), 32'(e_cout));
            check("op_ovf", 32'(ovf), 32'(e_ovf));
        end
        drain();
    endtask

    initial begin
        // Reset held with in_valid high; nothing may leak into the pipeline.
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Full carry chain with latency: presented in cycle t, result visible in cycle t+2.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_t2_out_valid", 32'(out_valid), 32'd1);
        check("carry_sum", 32'(sum), 32'h0000);
        check("carry_cout", 32'(cout), 32'd1);
        check("carry_ovf", 32'(ovf), 32'd0);
        tick();
        drain();

        one_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        one_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        one_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Streaming: eight back-to-back mixed operations.
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), 1'(i % 2));
        end
        in_valid = 1'b0;
        drain();
        check("stream_consecutive_valid", 32'(max_run), 32'd8);

        // Backpressure: two ops fill the pipe, the third waits until out_ready rises.
        out_ready = 1'b0;
        x0 = n_xfer;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'h2345);
            check("stall_cout", 32'(cout), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
        check("bp_transfer_count", 32'(n_xfer - x0), 32'd3);

        // Reset on the edge after an accept discards the op.
        send(16'h0ABC, 16'h0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        x0 = n_xfer;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("midrst_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        check("midrst_transfer_count", 32'(n_xfer - x0), 32'd0);
        one_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
